// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Brief    : Shared types and defaults for the fetch/data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // Which requester owns the RAM read data arriving in the current cycle.
    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_I    = 2'd1,
        RESP_D    = 2'd2
    } resp_owner_t;

    localparam int c_MAX_D_STREAK_DEFAULT = 4;

    localparam logic [31:0] c_WORD_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & c_WORD_MASK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Fetch/data arbiter onto one single-port synchronous RAM, with a
//            bounded data-port streak and a one-cycle response tag.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = c_MAX_D_STREAK_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_kill,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        m_en,
    output logic [31:0] m_addr,
    output logic [3:0]  m_we,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    localparam int c_STREAK_W = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_D_STREAK);

    logic [c_STREAK_W-1:0] r_streak;
    resp_owner_t           r_tag;
    logic                  r_run;

    logic w_streak_hit;
    logic w_i_gnt;
    logic w_d_gnt;
    logic w_d_read;

    // r_run gates grants so nothing is granted until the first edge after reset release.
    always_comb begin
        w_streak_hit = (r_streak == c_STREAK_MAX);
        w_d_gnt      = r_run && d_req && !(i_req && w_streak_hit);
        w_i_gnt      = r_run && i_req && !w_d_gnt;
        w_d_read     = w_d_gnt && (d_we == 4'b0000);
    end

    assign i_gnt = w_i_gnt;
    assign d_gnt = w_d_gnt;

    always_comb begin
        m_en    = 1'b0;
        m_addr  = 32'h0;
        m_we    = 4'h0;
        m_wdata = 32'h0;
        if (w_d_gnt) begin
            m_en    = 1'b1;
            m_addr  = word_align(d_addr);
            m_we    = d_we;
            m_wdata = d_wdata;
        end else if (w_i_gnt) begin
            m_en    = 1'b1;
            m_addr  = word_align(i_addr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_streak <= '0;
        end else if (w_d_gnt && i_req) begin
            if (!w_streak_hit) begin
                r_streak <= r_streak + 1'b1;
            end
        end else begin
            r_streak <= '0;
        end
    end

    // Tag follows the current grant; a fetch squashed in its grant cycle never responds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag <= RESP_NONE;
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_i_gnt && !i_kill) begin
                r_tag <= RESP_I;
            end else if (w_d_read) begin
                r_tag <= RESP_D;
            end else begin
                r_tag <= RESP_NONE;
            end
        end
    end

    assign i_rvalid = (r_tag == RESP_I) && !i_kill;
    assign d_rvalid = (r_tag == RESP_D);
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed and random checks of mem_arbiter against a behavioural
//            model of grants, streak limit, responses and RAM contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int c_MAXS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic        i_kill = 1'b0;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [3:0]  d_we = 4'h0;
    logic [31:0] d_wdata = 32'h0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_en;
    logic [31:0] m_addr;
    logic [3:0]  m_we;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model state
    int          mdl_streak = 0;
    int          mdl_pend   = 0;   // 0 none, 1 fetch, 2 load
    bit          mdl_run    = 1'b0;
    logic [31:0] mdl_pdata  = 32'h0;
    logic [31:0] ref_mem [int];
    int          grant_log [$];

    logic        obs_irv, obs_drv;
    logic [31:0] obs_irdata, obs_drdata, obs_maddr;
    logic [3:0]  obs_mwe;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_D_STREAK(c_MAXS)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    function automatic logic [31:0] init_word(input logic [9:0] idx);
        return {idx, 6'h15, idx, 6'h2A};
    endfunction

    // Single-port synchronous RAM (4 KB), preset contents given by init_word.
    logic [31:0]   ram [0:1023];
    logic [1023:0] ram_wr = '0;
    logic [31:0]   ram_cur;
    always @(posedge clk) begin
        if (m_en) begin
            ram_cur = ram_wr[m_addr[11:2]] ? ram[m_addr[11:2]] : init_word(m_addr[11:2]);
            m_rdata <= ram_cur;
            if (m_we != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (m_we[b]) ram_cur[8*b +: 8] = m_wdata[8*b +: 8];
                ram[m_addr[11:2]]    <= ram_cur;
                ram_wr[m_addr[11:2]] <= 1'b1;
            end
        end
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int idx = int'(a[11:2]);
        return ref_mem.exists(idx) ? ref_mem[idx] : init_word(a[11:2]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already set (posedge+1); check mid-cycle, then advance.
    task automatic step(input bit drop_rst = 1'b0);
        bit          eg_i, eg_d, ei_rv, ed_rv;
        logic [31:0] e_addr, w;
        int          idx;
        #4;
        if (!rst) begin mdl_run = 1'b0; mdl_pend = 0; mdl_streak = 0; end
        eg_d   = mdl_run && d_req && !(i_req && mdl_streak >= c_MAXS);
        eg_i   = mdl_run && i_req && !eg_d;
        ei_rv  = (mdl_pend == 1) && !i_kill;
        ed_rv  = (mdl_pend == 2);
        e_addr = eg_d ? d_addr : (eg_i ? i_addr : 32'h0);
        e_addr[1:0] = 2'b00;
        chk("i_gnt", i_gnt, eg_i);
        chk("d_gnt", d_gnt, eg_d);
        chk("m_en", m_en, eg_i || eg_d);
        chk("m_addr", m_addr, e_addr);
        chk("m_we", m_we, eg_d ? d_we : 4'h0);
        if (!eg_i) chk("m_wdata", m_wdata, eg_d ? d_wdata : 32'h0);
        chk("i_rvalid", i_rvalid, ei_rv);
        chk("d_rvalid", d_rvalid, ed_rv);
        if (ei_rv) chk("i_rdata", i_rdata, mdl_pdata);
        if (ed_rv) chk("d_rdata", d_rdata, mdl_pdata);
        obs_irv = i_rvalid; obs_drv = d_rvalid;
        obs_irdata = i_rdata; obs_drdata = d_rdata;
        obs_maddr = m_addr; obs_mwe = m_we;
        grant_log.push_back(i_gnt ? 1 : (d_gnt ? 2 : 0));
        if (drop_rst) begin #2; rst = 1'b0; end
        @(posedge clk);
        if (!rst) begin
            mdl_run = 1'b0; mdl_pend = 0; mdl_streak = 0;
        end else begin
            mdl_run = 1'b1;
            if (eg_d && i_req) mdl_streak = (mdl_streak < c_MAXS) ? mdl_streak + 1 : c_MAXS;
            else mdl_streak = 0;
            mdl_pend = 0;
            if (eg_i && !i_kill) begin
                mdl_pend = 1; mdl_pdata = mem_rd(i_addr);
            end else if (eg_d && d_we == 4'h0) begin
                mdl_pend = 2; mdl_pdata = mem_rd(d_addr);
            end else if (eg_d) begin
                idx = int'(d_addr[11:2]);
                w = mem_rd(d_addr);
                for (int b = 0; b < 4; b++)
                    if (d_we[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
                ref_mem[idx] = w;
            end
        end
        #1;
    endtask

    initial begin
        i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_addr = 32'h104;
        @(posedge clk); #1;
        step(); step();
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
        step();

        // Preload 0x100 with 0x13 through a full-word store
        d_req = 1'b1; d_addr = 32'h100; d_we = 4'hF; d_wdata = 32'h13;
        step();
        d_req = 1'b0; d_we = 4'h0;
        step();

        // Basic fetch
        i_req = 1'b1; i_addr = 32'h100;
        step();
        i_req = 1'b0;
        step();
        chk("fetch_rvalid", obs_irv, 1);
        chk("fetch_rdata", obs_irdata, 32'h13);

        // Both ports saturated: D,D,D,D,I repeating
        grant_log.delete();
        i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_addr = 32'h208; d_we = 4'h0;
        for (int k = 0; k < 15; k++) step();
        for (int k = 0; k < 15; k++) chk("streak_pattern", grant_log[k], (k % 5 == 4) ? 1 : 2);

        // Partial store then read back
        i_req = 1'b0; d_req = 1'b1; d_addr = 32'h203; d_we = 4'b0011; d_wdata = 32'hAABBCCDD;
        step();
        chk("store_maddr", obs_maddr, 32'h200);
        chk("store_mwe", obs_mwe, 4'b0011);
        d_addr = 32'h200; d_we = 4'h0;
        step();
        chk("store_no_rvalid", obs_drv, 0);
        d_req = 1'b0;
        step();
        chk("load_rvalid", obs_drv, 1);
        chk("load_halfword", obs_drdata[15:0], 16'hCCDD);

        // Fetch squashed in its response cycle, then a normal fetch
        i_req = 1'b1; i_addr = 32'h40;
        step();
        i_req = 1'b0; i_kill = 1'b1;
        step();
        chk("kill_rvalid", obs_irv, 0);
        i_kill = 1'b0; i_req = 1'b1; i_addr = 32'h44;
        step();
        i_req = 1'b0;
        step();
        chk("refetch_rvalid", obs_irv, 1);
        chk("refetch_rdata", obs_irdata, init_word(10'h011));

        // Reset asserted between a load grant and its response edge
        d_req = 1'b1; d_addr = 32'h100; d_we = 4'h0;
        step(1'b1);
        d_req = 1'b0;
        step();
        chk("rst_drop_rvalid", obs_drv, 0);
        step();
        rst = 1'b1; i_req = 1'b1; i_addr = 32'h100;
        step(); step();
        i_req = 1'b0;
        step();
        chk("post_rst_rvalid", obs_irv, 1);
        chk("post_rst_rdata", obs_irdata, 32'h13);

        // Random traffic with occasional reset pulses and kills
        for (int k = 0; k < 400; k++) begin
            rst     = ($urandom_range(0, 59) != 0);
            i_req   = ($urandom_range(0, 3) != 0);
            i_addr  = 32'($urandom_range(0, 4095));
            i_kill  = ($urandom_range(0, 5) == 0);
            d_req   = 1'($urandom_range(0, 1));
            d_addr  = 32'($urandom_range(0, 4095));
            d_we    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            d_wdata = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
